wb_block_master: RTL

- Command-driven Wishbone classic master. Moves a block of consecutive 32-bit words between the bus and simple valid/ready streams.
- Read command: fetches words from the bus and presents them on a read stream.
- Write command: drains a write stream onto the bus.
- Acts as the initiator side for the SoC's Wishbone RAM/peripheral slaves. Must tolerate slaves whose ack is registered one cycle after stb&cyc and re-asserts every cycle stb stays high.

---
 rtl/wb_block_master_if.sv | 52 +++++
 rtl/wb_block_master.sv | 138 +++++++++++++
 2 files changed

// File: rtl/wb_block_master_if.sv
// Bundled command, stream and Wishbone signals for wb_block_master.
// The master modport is the block itself; slave is the surrounding system.
interface wb_block_master_if #(
    parameter int unsigned LEN_WIDTH = 16
);
    logic                 cmd_start_i;
    logic                 cmd_write_i;
    logic [31:0]          cmd_addr_i;
    logic [LEN_WIDTH-1:0] cmd_len_i;
    logic                 busy_o;
    logic                 done_o;
    logic                 err_o;

    logic [31:0]          wr_data_i;
    logic                 wr_valid_i;
    logic                 wr_ready_o;
    logic [31:0]          rd_data_o;
    logic                 rd_valid_o;
    logic                 rd_ready_i;

    logic [31:0]          wb_adr_o;
    logic [31:0]          wb_dat_o;
    logic [31:0]          wb_dat_i;
    logic                 wb_cyc_o;
    logic                 wb_stb_o;
    logic [3:0]           wb_sel_o;
    logic                 wb_we_o;
    logic                 wb_ack_i;
    logic                 wb_err_i;

    modport master (
        input  cmd_start_i, cmd_write_i, cmd_addr_i, cmd_len_i,
        output busy_o, done_o, err_o,
        input  wr_data_i, wr_valid_i,
        output wr_ready_o,
        output rd_data_o, rd_valid_o,
        input  rd_ready_i,
        output wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_sel_o, wb_we_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        output cmd_start_i, cmd_write_i, cmd_addr_i, cmd_len_i,
        input  busy_o, done_o, err_o,
        output wr_data_i, wr_valid_i,
        input  wr_ready_o,
        input  rd_data_o, rd_valid_o,
        output rd_ready_i,
        input  wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_sel_o, wb_we_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/wb_block_master.sv
// Command-driven Wishbone classic master moving blocks of 32-bit words
// between the bus and valid/ready read/write streams.
module wb_block_master #(
    parameter int unsigned LEN_WIDTH = 16,
    parameter int unsigned TIMEOUT   = 255
) (
    input logic               wb_clk_i,
    input logic               wb_rst_i,
    wb_block_master_if.master bus
);
    localparam int unsigned TmoWidth = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StStrobe,
        StHold,
        StGap,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [31:0]          addr_q, addr_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic                 dir_q, dir_d;
    logic                 err_q, err_d;
    logic [TmoWidth-1:0]  tmo_q, tmo_d;
    logic [31:0]          wdat_q, wdat_d;
    logic [31:0]          rdat_q, rdat_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        err_d   = err_q;
        tmo_d   = '0;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        case (state_q)
            StIdle: begin
                if (bus.cmd_start_i) begin
                    addr_d = {bus.cmd_addr_i[31:2], 2'b00};
                    rem_d  = bus.cmd_len_i;
                    dir_d  = bus.cmd_write_i;
                    err_d  = 1'b0;
                    if (bus.cmd_len_i == '0) begin
                        state_d = StDone;
                    end else if (bus.cmd_write_i) begin
                        state_d = StFetch;
                    end else begin
                        state_d = StStrobe;
                    end
                end
            end
            StFetch: begin
                if (bus.wr_valid_i) begin
                    wdat_d  = bus.wr_data_i;
                    state_d = StStrobe;
                end
            end
            StStrobe: begin
                // err wins over a simultaneous ack; errored read data never reaches the stream
                if (bus.wb_err_i) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else if (bus.wb_ack_i) begin
                    if (!dir_q) begin
                        rdat_d = bus.wb_dat_i;
                    end
                    state_d = dir_q ? StGap : StHold;
                end else if (tmo_q == TmoWidth'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StHold: begin
                if (bus.rd_ready_i) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                // Idle bus cycle swallows the repeated ack of registered-ack slaves
                rem_d  = rem_q - LEN_WIDTH'(1);
                addr_d = addr_q + 32'd4;
                if (rem_q == LEN_WIDTH'(1)) begin
                    state_d = StDone;
                end else begin
                    state_d = dir_q ? StFetch : StStrobe;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
        end
    end

    assign bus.busy_o     = (state_q != StIdle) && (state_q != StDone);
    assign bus.done_o     = (state_q == StDone);
    assign bus.err_o      = (state_q == StDone) && err_q;
    assign bus.wr_ready_o = (state_q == StFetch);
    assign bus.rd_valid_o = (state_q == StHold);
    assign bus.rd_data_o  = rdat_q;
    assign bus.wb_cyc_o   = (state_q == StStrobe);
    assign bus.wb_stb_o   = (state_q == StStrobe);
    assign bus.wb_sel_o   = (state_q == StStrobe) ? 4'hF : 4'h0;
    assign bus.wb_we_o    = (state_q == StStrobe) && dir_q;
    assign bus.wb_adr_o   = addr_q;
    assign bus.wb_dat_o   = wdat_q;

endmodule
